// File: rtl/axis_bram_capture.sv
// axis_bram_capture: captures words from an AXI4-stream ADC feed into a simple-dual-port BRAM.
//
// The stream is never stalled. s_tready is 1 whenever rst is low. Beats that arrive outside a
// capture are accepted and dropped. A start pulse in IDLE or DONE arms a capture, which latches
// length, decim and stop_on_last. During the capture, one beat out of every decim+1 accepted
// beats is written to consecutive BRAM words, starting at address 0. The capture ends when
// length words have been written, or, with stop_on_last set, on an accepted tlast beat.
//
// Ports
//   clk, rst       single clock, synchronous active-high reset
//   start          one-cycle capture request (ignored while capturing)
//   length         words to store; 0 or anything above 2^ADDR_WIDTH means 2^ADDR_WIDTH
//   decim          store one beat of every decim+1 accepted beats
//   stop_on_last   end the capture on an accepted tlast beat
//   s_t*           AXI4-stream slave
//   bram_*         BRAM write port, registered, one cycle after the stored beat
//   busy, done     capture in progress / capture complete (sticky)
//   wr_count       words written in the current or last capture
module axis_bram_capture #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     length,
  input  logic [7:0]              decim,
  input  logic                    stop_on_last,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    bram_en,
  output logic [DATA_WIDTH/8-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic [DATA_WIDTH-1:0]   bram_din,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     wr_count
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] FullLen = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [7:0]              decim_q;
  logic                    sol_q;
  logic [7:0]              dec_cnt_q;
  logic [ADDR_WIDTH:0]     wr_count_q;
  logic                    bram_en_q;
  logic [ADDR_WIDTH-1:0]   bram_addr_q;
  logic [DATA_WIDTH-1:0]   bram_din_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    accept;
  logic                    store;
  logic                    finish;
  logic [ADDR_WIDTH:0]     wr_count_inc;
  logic [ADDR_WIDTH:0]     len_clamped;

  always_comb begin
    accept       = s_tvalid & s_tready;
    store        = (state_q == StCapture) & accept & (dec_cnt_q == 8'd0);
    wr_count_inc = wr_count_q + CntOne;
    // Word-count limit and tlast stop can coincide; both just request DONE.
    finish       = (store & (wr_count_inc == len_q)) |
                   ((state_q == StCapture) & accept & sol_q & s_tlast);
    len_clamped  = ((length == '0) || (length > FullLen)) ? FullLen : length;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      decim_q     <= '0;
      sol_q       <= 1'b0;
      dec_cnt_q   <= '0;
      wr_count_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bram_en_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          // First DONE cycle still shows busy while the final write is on the port.
          if ((state_q == StDone) && busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          if (start) begin
            state_q    <= StCapture;
            len_q      <= len_clamped;
            decim_q    <= decim;
            sol_q      <= stop_on_last;
            wr_count_q <= '0;
            dec_cnt_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StCapture: begin
          if (accept) begin
            dec_cnt_q <= (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
          end
          if (store) begin
            bram_en_q   <= 1'b1;
            bram_addr_q <= wr_count_q[ADDR_WIDTH-1:0];
            bram_din_q  <= s_tdata;
            wr_count_q  <= wr_count_inc;
          end
          if (finish) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gate with rst so that a write already registered from the previous beat never reaches
  // the BRAM once reset is asserted.
  assign s_tready  = ~rst;
  assign bram_en   = bram_en_q & ~rst;
  assign bram_we   = {BeWidth{bram_en}};
  assign bram_addr = rst ? '0 : bram_addr_q;
  assign bram_din  = rst ? '0 : bram_din_q;
  assign busy      = busy_q & ~rst;
  assign done      = done_q & ~rst;
  assign wr_count  = rst ? '0 : wr_count_q;

endmodule

// File: tb/tb_axis_bram_capture.sv
module tb_axis_bram_capture;

  localparam int unsigned DW  = 16;
  localparam int unsigned AWB = 7;
  localparam int unsigned AWS = 4;

  logic clk = 1'b0;
  logic rst, start, sol, tvalid, tlast;
  logic [AWB:0] length_b;
  logic [AWS:0] length_s;
  logic [7:0] decim;
  logic [DW-1:0] tdata;

  logic tready_b, en_b, busy_b, done_b;
  logic [1:0] we_b;
  logic [AWB-1:0] addr_b;
  logic [DW-1:0] din_b;
  logic [AWB:0] wcnt_b;

  logic tready_s, en_s, busy_s, done_s;
  logic [1:0] we_s;
  logic [AWS-1:0] addr_s;
  logic [DW-1:0] din_s;
  logic [AWS:0] wcnt_s;

  axis_bram_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWB)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length_b), .decim(decim),
    .stop_on_last(sol), .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast),
    .s_tready(tready_b), .bram_en(en_b), .bram_we(we_b), .bram_addr(addr_b),
    .bram_din(din_b), .busy(busy_b), .done(done_b), .wr_count(wcnt_b)
  );

  axis_bram_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWS)) dut_s (
    .clk(clk), .rst(rst), .start(start), .length(length_s), .decim(decim),
    .stop_on_last(sol), .s_tdata(tdata), .s_tvalid(tvalid), .s_tlast(tlast),
    .s_tready(tready_s), .bram_en(en_s), .bram_we(we_s), .bram_addr(addr_s),
    .bram_din(din_s), .busy(busy_s), .done(done_s), .wr_count(wcnt_s)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int we_err = 0;
  logic [AWB-1:0] qa_b[$];
  logic [DW-1:0]  qd_b[$];
  logic [AWS-1:0] qa_s[$];
  logic [DW-1:0]  qd_s[$];

  // Write logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (en_b === 1'b1) begin
      qa_b.push_back(addr_b);
      qd_b.push_back(din_b);
      if (we_b !== 2'b11) we_err++;
    end else if (we_b !== 2'b00) begin
      we_err++;
    end
    if (en_s === 1'b1) begin
      qa_s.push_back(addr_s);
      qd_s.push_back(din_s);
      if (we_s !== 2'b11) we_err++;
    end else if (we_s !== 2'b00) begin
      we_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tick();
  endtask

  task automatic gap();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tick();
  endtask

  task automatic go(input logic [AWB:0] lb, input logic [AWS:0] ls, input logic [7:0] dc,
                    input logic so);
    length_b = lb;
    length_s = ls;
    decim    = dc;
    sol      = so;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic clear_q();
    qa_b.delete();
    qd_b.delete();
    qa_s.delete();
    qd_s.delete();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_wb(input string tag, input int i, input int a, input int d);
    chk($sformatf("%s_addr%0d", tag, i), 64'(qa_b[i]), 64'(a));
    chk($sformatf("%s_data%0d", tag, i), 64'(qd_b[i]), 64'(d));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sol = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    length_b = '0; length_s = '0; decim = '0; tdata = '0;
    tick();
    tick();
    // Reset state
    chk("rst_tready", tready_b, 0);
    chk("rst_en", en_b, 0);
    chk("rst_we", we_b, 0);
    chk("rst_addr", addr_b, 0);
    chk("rst_din", din_b, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_b, 0);
    chk("rst_wcnt", wcnt_b, 0);
    rst = 1'b0;
    tick();
    chk("idle_tready", tready_b, 1);
    chk("idle_busy", busy_b, 0);

    // Basic: length 4, data 1..5, one-cycle write latency
    clear_q();
    go(8'd4, 5'd0, 8'd0, 1'b0);
    chk("b_busy", busy_b, 1);
    chk("b_wcnt0", wcnt_b, 0);
    for (int i = 1; i <= 5; i++) begin
      beat(DW'(i), 1'b0);
      if (i <= 4) begin
        chk($sformatf("b_en%0d", i), en_b, 1);
        chk($sformatf("b_addr%0d", i), addr_b, i - 1);
        chk($sformatf("b_din%0d", i), din_b, i);
        chk($sformatf("b_wcnt%0d", i), wcnt_b, i);
      end else begin
        chk("b_en5", en_b, 0);
      end
    end
    gap();
    gap();
    chk("b_nwr", qa_b.size(), 4);
    chk("b_done", done_b, 1);
    chk("b_busy_end", busy_b, 0);
    chk("b_wcnt", wcnt_b, 4);
    chk("b_addr_hold", addr_b, 3);
    chk("b_din_hold", din_b, 4);

    // Decimation with gaps: length 3, decim 2, data 10..18 on every other cycle
    clear_q();
    go(8'd3, 5'd0, 8'd2, 1'b0);
    for (int k = 0; k < 18; k++) begin
      if (k % 2 == 0) beat(DW'(10 + k / 2), 1'b0);
      else gap();
    end
    gap();
    chk("d_nwr", qa_b.size(), 3);
    chk_wb("d", 0, 0, 10);
    chk_wb("d", 1, 1, 13);
    chk_wb("d", 2, 2, 16);
    chk("d_done", done_b, 1);
    chk("d_wcnt", wcnt_b, 3);

    // Early stop on tlast, restart from DONE
    clear_q();
    go(8'd100, 5'd0, 8'd0, 1'b1);
    chk("r_done_clr", done_b, 0);
    chk("r_wcnt_clr", wcnt_b, 0);
    chk("r_busy", busy_b, 1);
    for (int i = 1; i <= 7; i++) beat(DW'(i), i == 5);
    gap();
    gap();
    chk("e_nwr", qa_b.size(), 5);
    for (int i = 0; i < 5; i++) chk_wb("e", i, i, i + 1);
    chk("e_wcnt", wcnt_b, 5);
    chk("e_done", done_b, 1);

    clear_q();
    go(8'd100, 5'd0, 8'd1, 1'b1);
    for (int i = 1; i <= 7; i++) beat(DW'(i), i == 5);
    gap();
    gap();
    chk("e2_nwr", qa_b.size(), 3);
    chk_wb("e2", 0, 0, 1);
    chk_wb("e2", 1, 1, 3);
    chk_wb("e2", 2, 2, 5);
    chk("e2_wcnt", wcnt_b, 3);
    chk("e2_done", done_b, 1);

    // Full depth on the 4-bit-address instance: length 0, then 31 (clamps to 16)
    do_reset();
    clear_q();
    go(8'd0, 5'd0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) beat(DW'(100 + i), 1'b0);
    gap();
    gap();
    chk("f_nwr", qa_s.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("f_addr%0d", i), qa_s[i], i);
      chk($sformatf("f_data%0d", i), qd_s[i], 100 + i);
    end
    chk("f_wcnt", wcnt_s, 16);
    chk("f_done", done_s, 1);
    chk("f_addr_hold", addr_s, 15);

    clear_q();
    go(8'd0, 5'd31, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) beat(DW'(200 + i), 1'b0);
    gap();
    gap();
    chk("c_nwr", qa_s.size(), 16);
    chk("c_first", qd_s[0], 200);
    chk("c_last_addr", qa_s[15], 15);
    chk("c_last_data", qd_s[15], 215);
    chk("c_wcnt", wcnt_s, 16);
    chk("c_done", done_s, 1);

    // Mid-capture start ignored, then reset with a write pending
    do_reset();
    clear_q();
    go(8'd8, 5'd0, 8'd0, 1'b0);
    beat(DW'(1), 1'b0);
    length_b = 8'd2;
    decim    = 8'd5;
    start    = 1'b1;
    beat(DW'(2), 1'b0);
    start    = 1'b0;
    chk("m_wcnt2", wcnt_b, 2);
    chk("m_busy", busy_b, 1);
    beat(DW'(3), 1'b0);
    rst = 1'b1;
    #1;
    chk("m_rst_en", en_b, 0);
    chk("m_rst_we", we_b, 0);
    chk("m_rst_addr", addr_b, 0);
    chk("m_rst_din", din_b, 0);
    chk("m_rst_busy", busy_b, 0);
    chk("m_rst_wcnt", wcnt_b, 0);
    chk("m_rst_tready", tready_b, 0);
    beat(DW'(4), 1'b0);
    beat(DW'(5), 1'b0);
    chk("m_rst_en2", en_b, 0);
    rst = 1'b0;
    beat(DW'(6), 1'b0);
    beat(DW'(7), 1'b0);
    gap();
    chk("m_nwr", qa_b.size(), 2);
    chk_wb("m", 0, 0, 1);
    chk_wb("m", 1, 1, 2);
    chk("m_idle_busy", busy_b, 0);
    chk("m_idle_done", done_b, 0);

    clear_q();
    go(8'd3, 5'd0, 8'd0, 1'b0);
    for (int i = 21; i <= 24; i++) beat(DW'(i), 1'b0);
    gap();
    gap();
    chk("n_nwr", qa_b.size(), 3);
    chk_wb("n", 0, 0, 21);
    chk_wb("n", 1, 1, 22);
    chk_wb("n", 2, 2, 23);
    chk("n_done", done_b, 1);

    chk("we_consistency", we_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_bram_capture.md
AXIS_BRAM_CAPTURE -- requirements
Module: axis_bram_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the AXI4-stream sample word and BRAM data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 13, meaning the BRAM word-address width (depth 2^ADDR_WIDTH words).
REQ-003 SHALL have ports, in this order:
- clk  input  1  single clock for stream, BRAM and control
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle capture request
- length  input  ADDR_WIDTH+1  words to store; 0 means 2^ADDR_WIDTH
- decim  input  8  store one beat of every decim+1 accepted beats
- stop_on_last  input  1  end capture early on accepted tlast
- s_tdata  input  DATA_WIDTH  stream data
- s_tvalid  input  1  stream valid
- s_tlast  input  1  stream last
- s_tready  output  1  stream ready
- bram_en  output  1  BRAM enable
- bram_we  output  DATA_WIDTH/8  BRAM byte write enables
- bram_addr  output  ADDR_WIDTH  BRAM word address
- bram_din  output  DATA_WIDTH  BRAM write data
- busy  output  1  capture in progress
- done  output  1  capture complete, sticky
- wr_count  output  ADDR_WIDTH+1  words written in the current or last capture
REQ-004 SHALL use one clock (clk), with synchronous active-high reset (rst).

Function
REQ-005 SHALL implement states IDLE, CAPTURE, DONE.
REQ-006 SHALL drive s_tready=1 in all states when rst is low; beats outside CAPTURE are accepted and discarded (ADC sink never stalls).
REQ-007 IDLE or DONE with start=1 SHALL enter CAPTURE next cycle, latch length, decim and stop_on_last, clear wr_count, decimation counter and done, and set busy.
REQ-008 start while in CAPTURE SHALL be ignored.
REQ-009 length values above 2^ADDR_WIDTH SHALL clamp to 2^ADDR_WIDTH; length=0 SHALL mean 2^ADDR_WIDTH.
REQ-010 In CAPTURE, an accepted beat (s_tvalid & s_tready) SHALL be stored only when the decimation counter is 0. The counter increments per accepted beat and wraps from latched decim to 0.
REQ-011 A beat stored in cycle N SHALL produce in cycle N+1: bram_en=1, bram_we all ones, bram_addr=wr_count[ADDR_WIDTH-1:0], bram_din=that s_tdata. wr_count increments in cycle N+1. Latency is 1 cycle, registered outputs.
REQ-012 bram_en and bram_we SHALL be 0 in every cycle without a write; bram_addr and bram_din hold their last values.
REQ-013 When the write of word number length occurs, the FSM SHALL enter DONE in the same cycle the write is presented. busy=0 and done=1 from the next cycle. Later beats are not stored.
REQ-014 If stop_on_last is latched 1 and an accepted beat has s_tlast=1, capture SHALL end after that beat. The beat is stored if the decimation counter is 0; the state becomes DONE regardless.
REQ-015 A length-reached and a tlast stop in the same beat SHALL produce a single transition to DONE.
REQ-016 done SHALL stay 1 in DONE until the next accepted start or rst. wr_count holds its final value.
REQ-017 wr_count SHALL never exceed the latched length; bram_addr wraps only by reaching length=2^ADDR_WIDTH, never beyond.

Reset
REQ-018 While rst=1 the block SHALL hold s_tready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, wr_count=0, decimation counter 0, state IDLE.
REQ-019 rst asserted mid-CAPTURE SHALL abort the capture with no further BRAM write, including any write pending from the prior cycle's beat.
REQ-020 After rst deasserts, the block SHALL be in IDLE and require start to capture.

Verification
REQ-021 Basic: length=4, decim=0, continuous valid with data 1,2,3,4,5 -> writes addr 0..3 data 1..4, one cycle after each beat; done=1, wr_count=4; data 5 not written.
REQ-022 Decimation and backpressure-free gaps: length=3, decim=2, valid toggling every other cycle, data 10..18 -> stored 10,13,16 at addr 0,1,2; done=1.
REQ-023 Early stop: stop_on_last=1, length=100, tlast on 5th beat, decim=0 -> 5 writes, wr_count=5, done=1. Same case with decim=1 -> writes of beats 1,3,5; wr_count=3.
REQ-024 Full depth: ADDR_WIDTH=4, length=0 -> 16 writes at addr 0..15, wr_count=16, no 17th write. length=31 -> clamps to 16.
REQ-025 Mid-capture events: start pulsed during CAPTURE -> no effect. rst asserted after 2 of 8 writes -> no further bram_en, all outputs zero. A new start then writes from addr 0.
REQ-026 Restart from DONE: start in DONE -> done cleared next cycle, wr_count=0, new capture overwrites from addr 0.
